// File: rtl/mem_req_scheduler.sv
// mem_req_scheduler
//   Request front-end for the dual-port banked memory. Two valid/ready request
//   streams are each buffered in a FIFO. Requester 0 drives memory port A and
//   requester 1 drives port B. Same-address hazards (at least one write) are
//   serialised with alternating priority. Reads come back as registered, one-cycle
//   response pulses on the issuing requester's channel.
// Ports
//   clk, rst                 single clock, synchronous active-high reset
//   i_reqN_valid/we/addr/data  request stream N; o_reqN_ready = FIFO N not full
//   o_en*/o_we*/o_addr*/o_din*  memory port A/B controls (combinational from FIFO heads)
//   i_douta/i_doutb          memory read data, valid RD_LATENCY cycles after issue
//   o_rspN_valid/data        read response for requester N
//   o_conflict_cnt           saturating count of hazard cycles
module mem_req_scheduler #(
    parameter int DATA_W     = 12,
    parameter int ADDR_W     = 8,
    parameter int RD_LATENCY = 1,
    parameter int FIFO_DEPTH = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_req0_valid,
    output logic              o_req0_ready,
    input  logic              i_req0_we,
    input  logic [ADDR_W-1:0] i_req0_addr,
    input  logic [DATA_W-1:0] i_req0_data,
    input  logic              i_req1_valid,
    output logic              o_req1_ready,
    input  logic              i_req1_we,
    input  logic [ADDR_W-1:0] i_req1_addr,
    input  logic [DATA_W-1:0] i_req1_data,
    output logic              o_ena,
    output logic              o_enb,
    output logic              o_wea,
    output logic              o_web,
    output logic [ADDR_W-1:0] o_addra,
    output logic [ADDR_W-1:0] o_addrb,
    output logic [DATA_W-1:0] o_dina,
    output logic [DATA_W-1:0] o_dinb,
    input  logic [DATA_W-1:0] i_douta,
    input  logic [DATA_W-1:0] i_doutb,
    output logic              o_rsp0_valid,
    output logic [DATA_W-1:0] o_rsp0_data,
    output logic              o_rsp1_valid,
    output logic [DATA_W-1:0] o_rsp1_data,
    output logic [15:0]       o_conflict_cnt
);
    localparam int PW = $clog2(FIFO_DEPTH);

    typedef struct packed {
        logic              we;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
    } req_t;

    // Storage and state, index 0 = requester 0 / port A, 1 = requester 1 / port B
    req_t                         r_mem [2][FIFO_DEPTH];
    logic [1:0][PW:0]             r_wptr;
    logic [1:0][PW:0]             r_rptr;
    logic                         r_prio;
    logic [15:0]                  r_conflict_cnt;
    logic [1:0][RD_LATENCY-1:0]   r_vld_pipe;
    logic [1:0]                   r_rsp_valid;
    logic [1:0][DATA_W-1:0]       r_rsp_data;

    logic [1:0]                   w_in_valid;
    req_t [1:0]                   w_in_req;
    logic [1:0][DATA_W-1:0]       w_dout;
    logic [1:0]                   w_full;
    logic [1:0]                   w_hv;
    logic [1:0]                   w_push;
    logic [1:0]                   w_issue;
    req_t [1:0]                   w_head;
    req_t [1:0]                   w_port;
    logic                         w_hazard;

    assign w_in_valid  = {i_req1_valid, i_req0_valid};
    assign w_in_req[0] = {i_req0_we, i_req0_addr, i_req0_data};
    assign w_in_req[1] = {i_req1_we, i_req1_addr, i_req1_data};
    assign w_dout      = {i_doutb, i_douta};

    always_comb begin
        w_full = '0;
        w_hv   = '0;
        w_push = '0;
        w_head = '0;
        for (int q = 0; q < 2; q++) begin
            // Extra pointer bit separates full (MSBs differ) from empty (equal)
            w_full[q] = (r_wptr[q][PW] != r_rptr[q][PW]) &&
                        (r_wptr[q][PW-1:0] == r_rptr[q][PW-1:0]);
            w_hv[q]   = (r_wptr[q] != r_rptr[q]);
            w_head[q] = r_mem[q][r_rptr[q][PW-1:0]];
            w_push[q] = w_in_valid[q] && !w_full[q];
        end
    end

    // Only heads and prio feed the ports, so nothing from i_req* reaches them
    assign w_hazard   = (&w_hv) && (w_head[0].addr == w_head[1].addr) &&
                        (w_head[0].we || w_head[1].we);
    assign w_issue[0] = w_hv[0] && (!w_hazard || !r_prio);
    assign w_issue[1] = w_hv[1] && (!w_hazard ||  r_prio);

    always_comb begin
        w_port = '0;
        for (int q = 0; q < 2; q++)
            if (w_issue[q]) w_port[q] = w_head[q];
    end

    assign o_req0_ready   = !w_full[0];
    assign o_req1_ready   = !w_full[1];
    assign o_ena          = w_issue[0];
    assign o_enb          = w_issue[1];
    assign o_wea          = w_port[0].we;
    assign o_web          = w_port[1].we;
    assign o_addra        = w_port[0].addr;
    assign o_addrb        = w_port[1].addr;
    assign o_dina         = w_port[0].data;
    assign o_dinb         = w_port[1].data;
    assign o_rsp0_valid   = r_rsp_valid[0];
    assign o_rsp1_valid   = r_rsp_valid[1];
    assign o_rsp0_data    = r_rsp_data[0];
    assign o_rsp1_data    = r_rsp_data[1];
    assign o_conflict_cnt = r_conflict_cnt;

    // FIFO payload needs no reset; pointers define what is valid
    always_ff @(posedge clk) begin
        for (int q = 0; q < 2; q++)
            if (w_push[q]) r_mem[q][r_wptr[q][PW-1:0]] <= w_in_req[q];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wptr         <= '0;
            r_rptr         <= '0;
            r_prio         <= 1'b0;
            r_conflict_cnt <= '0;
            r_vld_pipe     <= '0;
            r_rsp_valid    <= '0;
            r_rsp_data     <= '0;
        end else begin
            for (int q = 0; q < 2; q++) begin
                if (w_push[q])  r_wptr[q] <= r_wptr[q] + (PW+1)'(1);
                if (w_issue[q]) r_rptr[q] <= r_rptr[q] + (PW+1)'(1);
                for (int s = RD_LATENCY-1; s > 0; s--)
                    r_vld_pipe[q][s] <= r_vld_pipe[q][s-1];
                r_vld_pipe[q][0] <= w_issue[q] && !w_head[q].we;
                // Last stage lines up with memory data on i_dout*
                r_rsp_valid[q] <= r_vld_pipe[q][RD_LATENCY-1];
                if (r_vld_pipe[q][RD_LATENCY-1]) r_rsp_data[q] <= w_dout[q];
            end
            if (w_hazard) begin
                r_prio <= !r_prio;
                if (r_conflict_cnt != 16'hFFFF) r_conflict_cnt <= r_conflict_cnt + 16'd1;
            end
        end
    end
endmodule

// File: tb/tb_mem_req_scheduler.sv
// Directed bench for mem_req_scheduler with a one-cycle-latency dual-port memory model.
module tb_mem_req_scheduler;
    localparam int DW = 12;
    localparam int AW = 8;

    logic          clk = 1'b0;
    logic          rst;
    logic          i_req0_valid, i_req0_we, i_req1_valid, i_req1_we;
    logic [AW-1:0] i_req0_addr, i_req1_addr;
    logic [DW-1:0] i_req0_data, i_req1_data;
    logic          o_req0_ready, o_req1_ready;
    logic          o_ena, o_enb, o_wea, o_web;
    logic [AW-1:0] o_addra, o_addrb;
    logic [DW-1:0] o_dina, o_dinb;
    logic [DW-1:0] douta, doutb;
    logic          o_rsp0_valid, o_rsp1_valid;
    logic [DW-1:0] o_rsp0_data, o_rsp1_data;
    logic [15:0]   o_conflict_cnt;

    int n_cmp = 0;
    int n_err = 0;

    mem_req_scheduler #(.DATA_W(DW), .ADDR_W(AW), .RD_LATENCY(1), .FIFO_DEPTH(4)) dut (
        .clk(clk), .rst(rst),
        .i_req0_valid(i_req0_valid), .o_req0_ready(o_req0_ready), .i_req0_we(i_req0_we),
        .i_req0_addr(i_req0_addr), .i_req0_data(i_req0_data),
        .i_req1_valid(i_req1_valid), .o_req1_ready(o_req1_ready), .i_req1_we(i_req1_we),
        .i_req1_addr(i_req1_addr), .i_req1_data(i_req1_data),
        .o_ena(o_ena), .o_enb(o_enb), .o_wea(o_wea), .o_web(o_web),
        .o_addra(o_addra), .o_addrb(o_addrb), .o_dina(o_dina), .o_dinb(o_dinb),
        .i_douta(douta), .i_doutb(doutb),
        .o_rsp0_valid(o_rsp0_valid), .o_rsp0_data(o_rsp0_data),
        .o_rsp1_valid(o_rsp1_valid), .o_rsp1_data(o_rsp1_data),
        .o_conflict_cnt(o_conflict_cnt)
    );

    always #5 clk = ~clk;

    // Memory model: RD_LATENCY = 1, contents start as {4'h8, addr}, never reset
    logic [DW-1:0] mem [256];
    bit            mem_init = 1'b0;
    always @(posedge clk) begin
        if (!mem_init) begin
            for (int i = 0; i < 256; i++) mem[i] <= {4'h8, 8'(i)};
            douta    <= '0;
            doutb    <= '0;
            mem_init <= 1'b1;
        end else begin
            if (o_ena) begin
                if (o_wea) mem[o_addra] <= o_dina;
                douta <= mem[o_addra];
            end
            if (o_enb) begin
                if (o_web) mem[o_addrb] <= o_dinb;
                doutb <= mem[o_addrb];
            end
        end
    end

    task automatic next_cyc;
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs;
        i_req0_valid = 0; i_req0_we = 0; i_req0_addr = '0; i_req0_data = '0;
        i_req1_valid = 0; i_req1_we = 0; i_req1_addr = '0; i_req1_data = '0;
    endtask

    // Leaves the bench in cycle 0: #1 after the edge that released reset
    task automatic reset_dut;
        rst = 1;
        idle_inputs();
        repeat (2) @(posedge clk);
        #1 rst = 0;
    endtask

    task automatic test_reset;
        reset_dut();
        @(negedge clk);
        n_cmp++; if ({o_req0_ready, o_req1_ready} !== 2'b11) begin n_err++;
            $display("FAIL reset_ready: got %b want 11", {o_req0_ready, o_req1_ready}); end
        n_cmp++; if ({o_ena, o_enb, o_wea, o_web} !== 4'b0) begin n_err++;
            $display("FAIL reset_en_we: got %b want 0000", {o_ena, o_enb, o_wea, o_web}); end
        n_cmp++; if ({o_addra, o_addrb, o_dina, o_dinb} !== '0) begin n_err++;
            $display("FAIL reset_addr_din: got %h want 0", {o_addra, o_addrb, o_dina, o_dinb}); end
        n_cmp++; if ({o_rsp0_valid, o_rsp1_valid, o_rsp0_data, o_rsp1_data} !== '0) begin n_err++;
            $display("FAIL reset_rsp: got %h want 0", {o_rsp0_valid, o_rsp1_valid, o_rsp0_data, o_rsp1_data}); end
        n_cmp++; if (o_conflict_cnt !== 16'h0) begin n_err++;
            $display("FAIL reset_cnt: got %h want 0000", o_conflict_cnt); end
    endtask

    task automatic test_single_read;
        reset_dut();
        i_req0_valid = 1; i_req0_we = 1; i_req0_addr = 8'h05; i_req0_data = 12'hABC;
        next_cyc();                                   // cycle 1: write issues, read offered
        i_req0_we = 0; i_req0_data = '0;
        @(negedge clk);
        n_cmp++; if ({o_ena, o_wea, o_addra, o_dina} !== {1'b1, 1'b1, 8'h05, 12'hABC}) begin n_err++;
            $display("FAIL single_wr_issue: got %b %b %h %h want 1 1 05 abc", o_ena, o_wea, o_addra, o_dina); end
        next_cyc();                                   // cycle 2: read issues
        i_req0_valid = 0;
        @(negedge clk);
        n_cmp++; if ({o_ena, o_wea, o_addra} !== {1'b1, 1'b0, 8'h05}) begin n_err++;
            $display("FAIL single_rd_issue: got %b %b %h want 1 0 05", o_ena, o_wea, o_addra); end
        next_cyc();                                   // cycle 3: memory data valid
        @(negedge clk);
        n_cmp++; if ({o_ena, o_rsp0_valid} !== 2'b00) begin n_err++;
            $display("FAIL single_rsp_early: got en=%b vld=%b want 0 0", o_ena, o_rsp0_valid); end
        next_cyc();                                   // cycle 4 = issue + RD_LATENCY + 1
        @(negedge clk);
        n_cmp++; if ({o_rsp0_valid, o_rsp0_data} !== {1'b1, 12'hABC}) begin n_err++;
            $display("FAIL single_rsp: got vld=%b data=%h want 1 abc", o_rsp0_valid, o_rsp0_data); end
        next_cyc();
        @(negedge clk);
        n_cmp++; if ({o_rsp0_valid, o_rsp1_valid} !== 2'b00) begin n_err++;
            $display("FAIL single_rsp_pulse: got %b want 00", {o_rsp0_valid, o_rsp1_valid}); end
    endtask

    task automatic test_parallel;
        reset_dut();
        i_req0_valid = 1; i_req0_we = 0; i_req0_addr = 8'h10;
        i_req1_valid = 1; i_req1_we = 0; i_req1_addr = 8'h50;
        next_cyc();
        idle_inputs();
        @(negedge clk);
        n_cmp++; if ({o_ena, o_enb, o_wea, o_web, o_addra, o_addrb} !== {4'b1100, 8'h10, 8'h50}) begin n_err++;
            $display("FAIL parallel_issue: got %b%b%b%b %h %h want 1100 10 50", o_ena, o_enb, o_wea, o_web, o_addra, o_addrb); end
        repeat (2) next_cyc();
        @(negedge clk);
        n_cmp++; if ({o_rsp0_valid, o_rsp1_valid, o_rsp0_data, o_rsp1_data} !== {2'b11, 12'h810, 12'h850}) begin n_err++;
            $display("FAIL parallel_rsp: got %b%b %h %h want 11 810 850", o_rsp0_valid, o_rsp1_valid, o_rsp0_data, o_rsp1_data); end
        n_cmp++; if (o_conflict_cnt !== 16'h0) begin n_err++;
            $display("FAIL parallel_cnt: got %h want 0000", o_conflict_cnt); end
    endtask

    task automatic test_hazard;
        reset_dut();
        i_req0_valid = 1; i_req0_we = 1; i_req0_addr = 8'h20; i_req0_data = 12'h5A5;
        i_req1_valid = 1; i_req1_we = 0; i_req1_addr = 8'h20;
        next_cyc();                                   // cycle 1: hazard, prio 0 -> A
        idle_inputs();
        @(negedge clk);
        n_cmp++; if ({o_ena, o_wea, o_enb, o_conflict_cnt} !== {3'b110, 16'd0}) begin n_err++;
            $display("FAIL hazard_first: got %b%b%b cnt=%h want 110 cnt=0000", o_ena, o_wea, o_enb, o_conflict_cnt); end
        next_cyc();                                   // cycle 2: B alone
        @(negedge clk);
        n_cmp++; if ({o_ena, o_enb, o_web, o_addrb, o_conflict_cnt} !== {3'b010, 8'h20, 16'd1}) begin n_err++;
            $display("FAIL hazard_second: got %b%b%b %h cnt=%h want 010 20 cnt=0001", o_ena, o_enb, o_web, o_addrb, o_conflict_cnt); end
        repeat (2) next_cyc();                        // cycle 4: B read response
        @(negedge clk);
        n_cmp++; if ({o_rsp1_valid, o_rsp1_data} !== {1'b1, 12'h5A5}) begin n_err++;
            $display("FAIL hazard_rsp: got vld=%b data=%h want 1 5a5", o_rsp1_valid, o_rsp1_data); end
        // prio is now 1: a fresh write/write hazard must favour B
        i_req0_valid = 1; i_req0_we = 1; i_req0_addr = 8'h21; i_req0_data = 12'h111;
        i_req1_valid = 1; i_req1_we = 1; i_req1_addr = 8'h21; i_req1_data = 12'h222;
        next_cyc();
        idle_inputs();
        @(negedge clk);
        n_cmp++; if ({o_ena, o_enb, o_conflict_cnt} !== {2'b01, 16'd1}) begin n_err++;
            $display("FAIL hazard_prio1: got %b%b cnt=%h want 01 cnt=0001", o_ena, o_enb, o_conflict_cnt); end
        next_cyc();
        @(negedge clk);
        n_cmp++; if ({o_ena, o_enb, o_conflict_cnt} !== {2'b10, 16'd2}) begin n_err++;
            $display("FAIL hazard_prio0: got %b%b cnt=%h want 10 cnt=0002", o_ena, o_enb, o_conflict_cnt); end
    endtask

    // A keeps writing 8'h60 while B reads 8'h60. B still wins every other hazard,
    // so FIFO 1 fills at half rate: full after the 6th accept, the 7th is held
    // through cycle 6 and enters at the end of cycle 7.
    task automatic test_full_fifo;
        logic [7:0] exp_rdy;
        logic [7:0] exp_enb;
        int bacc, nb, nr;
        exp_rdy = 8'b1011_1111;
        exp_enb = 8'b0101_0100;
        bacc = 0; nb = 0; nr = 0;
        reset_dut();
        for (int c = 0; c < 8; c++) begin
            i_req0_valid = 1; i_req0_we = 1; i_req0_addr = 8'h60; i_req0_data = 12'h3C3;
            i_req1_valid = (bacc < 7); i_req1_we = 0; i_req1_addr = 8'h60;
            @(negedge clk);
            n_cmp++; if (o_req1_ready !== exp_rdy[c]) begin n_err++;
                $display("FAIL full_ready_c%0d: got %b want %b", c, o_req1_ready, exp_rdy[c]); end
            n_cmp++; if (o_enb !== exp_enb[c]) begin n_err++;
                $display("FAIL full_enb_c%0d: got %b want %b", c, o_enb, exp_enb[c]); end
            if (o_enb) nb++;
            if (o_rsp1_valid) nr++;
            if (i_req1_valid && o_req1_ready) bacc++;
            next_cyc();
        end
        idle_inputs();
        for (int c = 0; c < 30; c++) begin
            @(negedge clk);
            if (o_enb) nb++;
            if (o_rsp1_valid) nr++;
            next_cyc();
        end
        n_cmp++; if (nb !== 7) begin n_err++;
            $display("FAIL full_b_issues: got %0d want 7", nb); end
        n_cmp++; if (nr !== 7) begin n_err++;
            $display("FAIL full_b_responses: got %0d want 7", nr); end
    endtask

    task automatic test_reset_midflight;
        int nrsp;
        nrsp = 0;
        reset_dut();
        i_req0_valid = 1; i_req0_we = 0; i_req0_addr = 8'h30;
        i_req1_valid = 1; i_req1_we = 0; i_req1_addr = 8'h31;
        next_cyc();                                   // cycle 1: reads issue, more offered
        i_req0_addr = 8'h32; i_req1_addr = 8'h33;
        next_cyc();                                   // cycle 2: rst high
        idle_inputs();
        rst = 1;
        next_cyc();                                   // cycle 3: first cycle after reset
        rst = 0;
        @(negedge clk);
        n_cmp++; if ({o_ena, o_enb, o_wea, o_web, o_addra, o_addrb, o_dina, o_dinb} !== '0) begin n_err++;
            $display("FAIL midrst_ports: got %b%b%b%b %h %h %h %h want all 0", o_ena, o_enb, o_wea, o_web, o_addra, o_addrb, o_dina, o_dinb); end
        n_cmp++; if ({o_req0_ready, o_req1_ready, o_conflict_cnt} !== {2'b11, 16'd0}) begin n_err++;
            $display("FAIL midrst_ready_cnt: got %b%b %h want 11 0000", o_req0_ready, o_req1_ready, o_conflict_cnt); end
        n_cmp++; if ({o_rsp0_data, o_rsp1_data} !== '0) begin n_err++;
            $display("FAIL midrst_rsp_data: got %h %h want 000 000", o_rsp0_data, o_rsp1_data); end
        for (int c = 0; c < 6; c++) begin
            if (o_rsp0_valid || o_rsp1_valid) nrsp++;
            next_cyc();
            @(negedge clk);
        end
        n_cmp++; if (nrsp !== 0) begin n_err++;
            $display("FAIL midrst_no_rsp: got %0d responses want 0", nrsp); end
    endtask

    // Both sides write 8'h40 every cycle, so every cycle from 1 on is a hazard
    // and the count seen in cycle k is k-1 until it saturates.
    task automatic test_saturation;
        reset_dut();
        i_req0_valid = 1; i_req0_we = 1; i_req0_addr = 8'h40; i_req0_data = 12'h001;
        i_req1_valid = 1; i_req1_we = 1; i_req1_addr = 8'h40; i_req1_data = 12'h002;
        repeat (100) next_cyc();
        @(negedge clk);
        n_cmp++; if (o_conflict_cnt !== 16'd99) begin n_err++;
            $display("FAIL sat_cnt_100: got %0d want 99", o_conflict_cnt); end
        repeat (65435) next_cyc();
        @(negedge clk);
        n_cmp++; if (o_conflict_cnt !== 16'hFFFE) begin n_err++;
            $display("FAIL sat_cnt_fffe: got %h want fffe", o_conflict_cnt); end
        next_cyc();
        @(negedge clk);
        n_cmp++; if (o_conflict_cnt !== 16'hFFFF) begin n_err++;
            $display("FAIL sat_cnt_ffff: got %h want ffff", o_conflict_cnt); end
        repeat (5) next_cyc();
        @(negedge clk);
        n_cmp++; if (o_conflict_cnt !== 16'hFFFF) begin n_err++;
            $display("FAIL sat_cnt_hold: got %h want ffff", o_conflict_cnt); end
        idle_inputs();
    endtask

    initial begin
        rst = 1;
        idle_inputs();
        test_reset();
        test_single_read();
        test_parallel();
        test_hazard();
        test_full_fifo();
        test_reset_midflight();
        test_saturation();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/mem_req_scheduler.md
# mem_req_scheduler

Single-clock request front-end for the dual-port banked memory top. It accepts two independent valid/ready request streams, buffers each in its own FIFO, and drives port A (requester 0) and port B (requester 1) of the memory. It serialises same-address hazards between the two ports with alternating priority. It tracks read latency so every read returns as a tagged, registered response on the issuing requester's channel.

## Interface
- DATA_W, 12, data width; equals memory DATA_A/DATA_B
- ADDR_W, 8, address width; equals memory ADDR_A/ADDR_B; bank = addr[ADDR_W-1:ADDR_W-2]
- RD_LATENCY, 1, memory read latency in cycles (≥1); must equal memory RD_LATENCYA/B
- FIFO_DEPTH, 4, per-requester request FIFO depth (power of 2, ≥2)
- clk  in  1  single clock; also drives memory clka and clkb
- rst  in  1  synchronous, active-high reset
- i_req0_valid / i_req1_valid  in  1  request valid
- o_req0_ready / o_req1_ready  out  1  FIFO not full
- i_req0_we / i_req1_we  in  1  1 = write, 0 = read
- i_req0_addr / i_req1_addr  in  ADDR_W  request address
- i_req0_data / i_req1_data  in  DATA_W  write data
- o_ena, o_enb  out  1  memory port enables
- o_wea, o_web  out  1  memory port write enables
- o_addra, o_addrb  out  ADDR_W  memory port addresses
- o_dina, o_dinb  out  DATA_W  memory port write data
- i_douta, i_doutb  in  DATA_W  memory read data
- o_rsp0_valid / o_rsp1_valid  out  1  read response valid, one-cycle pulse
- o_rsp0_data / o_rsp1_data  out  DATA_W  read response data
- o_conflict_cnt  out  16  saturating count of hazard stalls

## Operation
- Push: request enters FIFO N when i_reqN_valid && o_reqN_ready.
- o_reqN_ready = !full. It stays low while full even if a pop occurs in the same cycle.
- Issue: a non-empty FIFO N presents its head on its port (0→A, 1→B) with en=1, we/addr/data taken from the head. The head pops in the same cycle.
- Port signals are combinational from FIFO head registers and the priority register only. There is no combinational path from i_req* to the o_en*/addr/din outputs.
- Hazard condition: both heads valid, addresses equal, and at least one of them is a write.
  - On a hazard, only the requester named by the prio register (0 or 1) issues. The other port holds en=0 and does not pop.
  - prio toggles after each hazard cycle.
  - o_conflict_cnt increments by 1, saturating at 16'hFFFF.
- Both heads valid to different addresses (same bank allowed, since memory is true dual-port): both issue.
- Empty FIFO: port en=0. we, addr and din are driven 0.
- Read tracking: each port has a RD_LATENCY-deep valid shift register.
  - Bit 0 is set on issue with we=0.
  - When the last stage is 1, i_doutX is registered into o_rspN_data and o_rspN_valid pulses.
- Responses per requester return strictly in issue order. No backpressure on responses.
- Writes produce no response.
- The memory top applies its own bank routing and ECC. Data passes through this block unchanged.

## Timing
- Reset values:
  - FIFOs empty, so o_req*_ready=1.
  - o_en*, o_we*, o_addr*, o_din* = 0.
  - prio = 0.
  - Latency pipes cleared.
  - o_rsp*_valid = 0 and o_rsp*_data = 0.
  - o_conflict_cnt = 0.
- Reset mid-operation: all queued requests and in-flight reads are discarded. No response is emitted for any read issued before reset.
- Accept-to-issue: a request accepted at edge T on an empty FIFO with no hazard drives its port during cycle T+1.
- Read return: issue in cycle I; memory data is valid on i_doutX in cycle I+RD_LATENCY; o_rspN_valid is high in cycle I+RD_LATENCY+1.
- Throughput: one issue per port per cycle, with back-to-back reads pipelined.
- FIFO pointers wrap modulo FIFO_DEPTH. Full and empty are distinguished by an extra pointer bit.
- Simultaneous push and pop on a non-full FIFO: occupancy is unchanged.
- Hazard that persists: the loser issues no later than the second hazard cycle, so there is no starvation.

## Test plan
- Single read: after reset, req0 write addr 8'h05 data 12'hABC, then req0 read addr 8'h05.
  - o_ena/o_wea = 1/1, then 1/0, on consecutive cycles.
  - o_rsp0_valid pulses RD_LATENCY+1 cycles after the read issue, with data 12'hABC.
- Parallel ports: req0 reads 8'h10 and req1 reads 8'h50 in the same cycle.
  - Both ports issue in one cycle.
  - Both responses arrive in the same cycle.
  - o_conflict_cnt stays 0.
- Hazard: req0 writes 8'h20, req1 reads 8'h20 simultaneously, starting from prio=0.
  - Port A issues first.
  - Port B issues the next cycle.
  - o_rsp1_data equals the written value.
  - o_conflict_cnt = 1 and prio = 1.
- Full FIFO: hold port B blocked by repeated hazards while pushing 5 req1 requests, with FIFO_DEPTH=4.
  - o_req1_ready drops after the 4th accept.
  - The 5th request is held until a pop occurs.
  - No request is lost or duplicated.
- Reset mid-flight: assert rst for 1 cycle in the cycle after a read issue.
  - No o_rsp*_valid appears afterwards.
  - All outputs are at reset values in the cycle after rst.
  - Ready is 1.
- Saturation: force 65 537 hazard cycles; o_conflict_cnt holds at 16'hFFFF.
